// File: rtl/divider_32bits.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// Define DIV_SIGNED_EN to add the signed_op port and truncating signed division.
module divider_32bits #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ZERO
  } state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    count;
  logic             neg_q;
  logic             neg_r;

  logic             dd_neg;
  logic             dv_neg;
  logic [WIDTH-1:0] dd_mag;
  logic [WIDTH-1:0] dv_mag;

`ifdef DIV_SIGNED_EN
  assign dd_neg = signed_op & dividend[WIDTH-1];
  assign dv_neg = signed_op & divisor[WIDTH-1];
`else
  assign dd_neg = 1'b0;
  assign dv_neg = 1'b0;
`endif

  assign dd_mag = dd_neg ? -dividend : dividend;
  assign dv_mag = dv_neg ? -divisor : divisor;

  // The partial remainder's sign bit is always zero between steps,
  // so only the shifted value is widened to WIDTH+1 for the trial.
  logic [WIDTH:0]   a_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] a_nx;
  logic [WIDTH-1:0] q_nx;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  always_comb begin
    a_sh  = {a, q[WIDTH-1]};
    trial = a_sh - {1'b0, d};
    q_nx  = {q[WIDTH-2:0], 1'b0};
    a_nx  = a_sh[WIDTH-1:0];
    if (!trial[WIDTH]) begin
      a_nx    = trial[WIDTH-1:0];
      q_nx[0] = 1'b1;
    end
  end

  assign q_fix = neg_q ? -q_nx : q_nx;
  assign r_fix = neg_r ? -a_nx : a_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a           <= '0;
      q           <= '0;
      d           <= '0;
      count       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            count <= '0;
            a     <= '0;
            neg_q <= dd_neg ^ dv_neg;
            neg_r <= dd_neg;
            if (divisor == '0) begin
              q     <= dividend;
              state <= ZERO;
            end else begin
              q     <= dd_mag;
              d     <= dv_mag;
              state <= RUN;
            end
          end
        end
        RUN: begin
          a     <= a_nx;
          q     <= q_nx;
          count <= count + 1'b1;
          if (count == LAST) begin
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        ZERO: begin
          quotient    <= '1;
          remainder   <= q;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_32bits.sv
// Directed bench for divider_32bits: timing, zero divide, boundaries,
// back-to-back, abort and (with DIV_SIGNED_EN) signed cases.
module tb_divider_32bits;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;
`ifdef DIV_SIGNED_EN
  logic        signed_op;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  divider_32bits #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
`ifdef DIV_SIGNED_EN
    .signed_op  (signed_op),
`endif
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  task automatic run_op(input logic [31:0] dd, input logic [31:0] dv,
                        output int lat);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
`ifdef DIV_SIGNED_EN
    signed_op = 1'b0;
`endif
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 000",
               {busy, done, div_by_zero});
    end
    vectors++;
    if (quotient !== 32'h0 || remainder !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_results: got q=%h r=%h expected 0/0",
               quotient, remainder);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i <= 33; i++) begin
      vectors++;
      if (busy !== (i < 32) || done !== (i == 32)) begin
        miscompares++;
        $display("FAIL basic_timing[%0d]: got busy=%b done=%b expected %b/%b",
                 i, busy, done, (i < 32), (i == 32));
      end
      if (i < 33) @(negedge clk);
    end
    vectors++;
    if (quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_result: got q=%0d r=%0d z=%b expected 14/2/0",
               quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_div_zero();
    int lat;
    run_op(32'h12345678, 32'h0, lat);
    vectors++;
    if (lat != 1) begin
      miscompares++;
      $display("FAIL zero_latency: got %0d expected 1", lat);
    end
    vectors++;
    if (quotient !== 32'hFFFFFFFF || remainder !== 32'h12345678 ||
        div_by_zero !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_result: got q=%h r=%h z=%b expected ffffffff/12345678/1",
               quotient, remainder, div_by_zero);
    end
    run_op(32'd9, 32'd3, lat);
    vectors++;
    if (lat != 32 || quotient !== 32'd3 || remainder !== 32'd0 ||
        div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_clear: got lat=%0d q=%0d r=%0d z=%b expected 32/3/0/0",
               lat, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] dd [3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5};
    logic [31:0] dv [3] = '{32'd1, 32'hFFFFFFFF, 32'd9};
    logic [31:0] eq [3] = '{32'hFFFFFFFF, 32'd1, 32'd0};
    logic [31:0] er [3] = '{32'd0, 32'd0, 32'd5};
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(dd[i], dv[i], lat);
      vectors++;
      if (lat != 32 || quotient !== eq[i] || remainder !== er[i]) begin
        miscompares++;
        $display("FAIL bound[%0d]: got lat=%0d q=%h r=%h expected 32/%h/%h",
                 i, lat, quotient, remainder, eq[i], er[i]);
      end
    end
    dividend = 32'hDEADBEEF;
    divisor  = 32'd3;
    repeat (3) @(negedge clk);
    vectors++;
    if (done !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd5) begin
      miscompares++;
      $display("FAIL bound_hold: got done=%b q=%h r=%h expected 0/0/5",
               done, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q [3] = '{32'd142, 32'd39, 32'd29};
    logic [31:0] exp_r [3] = '{32'd6, 32'd1, 32'd5};
    int          exp_c [3] = '{33, 66, 99};
    int n = 0;
    for (int c = 0; c < 100; c++) begin
      if (done) begin
        vectors++;
        if (n > 2) begin
          miscompares++;
          $display("FAIL b2b_extra: got done at cycle %0d expected none", c);
        end else if (c != exp_c[n] || quotient !== exp_q[n] ||
                     remainder !== exp_r[n]) begin
          miscompares++;
          $display("FAIL b2b[%0d]: got c=%0d q=%0d r=%0d expected %0d/%0d/%0d",
                   n, c, quotient, remainder, exp_c[n], exp_q[n], exp_r[n]);
        end
        n++;
      end
      start    = (c < 99);
      dividend = 32'(1000 + 17 * c);
      divisor  = 32'(7 + c);
      @(negedge clk);
    end
    start = 1'b0;
    vectors++;
    if (n != 3) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d expected 3", n);
    end
  endtask

  task automatic test_abort();
    int lat;
    int pulses = 0;
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'h0 ||
        remainder !== 32'h0) begin
      miscompares++;
      $display("FAIL abort_reset: got b/d/z=%b q=%h r=%h expected 000/0/0",
               {busy, done, div_by_zero}, quotient, remainder);
    end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL abort_done: got %0d pulses expected 0", pulses);
    end
    run_op(32'd100, 32'd7, lat);
    vectors++;
    if (lat != 32 || quotient !== 32'd14 || remainder !== 32'd2) begin
      miscompares++;
      $display("FAIL abort_restart: got lat=%0d q=%0d r=%0d expected 32/14/2",
               lat, quotient, remainder);
    end
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    logic        sg [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] dd [5] = '{32'hFFFFFFF9, 32'd7, 32'h80000000,
                            32'hFFFFFFFB, 32'hFFFFFFF9};
    logic [31:0] dv [5] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF,
                            32'd0, 32'd2};
    logic [31:0] eq [5] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000,
                            32'hFFFFFFFF, 32'h7FFFFFFC};
    logic [31:0] er [5] = '{32'hFFFFFFFF, 32'd1, 32'd0,
                            32'hFFFFFFFB, 32'd1};
    int          el [5] = '{32, 32, 32, 1, 32};
    int lat;
    for (int i = 0; i < 5; i++) begin
      signed_op = sg[i];
      run_op(dd[i], dv[i], lat);
      vectors++;
      if (lat != el[i] || quotient !== eq[i] || remainder !== er[i]) begin
        miscompares++;
        $display("FAIL signed[%0d]: got lat=%0d q=%h r=%h expected %0d/%h/%h",
                 i, lat, quotient, remainder, el[i], eq[i], er[i]);
      end
    end
    signed_op = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_boundaries();
    test_back_to_back();
    test_abort();
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/divider_32bits.md
Name: divider_32bits

Overview:
Sequential restoring divider, 32-bit. It produces quotient and remainder, one quotient bit per clock, using repeated trial subtraction. It is the inverse-direction companion to the team's carry-select adder, and it feeds the ALU result mux for DIV/REM-class operations. It uses a start/busy/done handshake, so the datapath stalls while it runs.

Parameters:
WIDTH, 32, operand and result width in bits (iteration count equals WIDTH).

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when busy=0.
dividend  input  WIDTH  numerator; captured on the accepting edge.
divisor  input  WIDTH  denominator; captured on the accepting edge.
signed_op  input  1  present only with DIV_SIGNED_EN; 1 selects signed divide.
quotient  output  WIDTH  result; held until the next completion.
remainder  output  WIDTH  result; held until the next completion.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse when results update.
div_by_zero  output  1  set with done when divisor was 0; held until the next completion.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, iteration counter=0.
- rst asserted mid-operation: the operation is aborted, everything returns to reset values, and no done pulse is produced.
- States: IDLE, RUN, ZERO.
- IDLE, start=1, divisor!=0: capture operands into internal registers A (partial remainder, WIDTH+1 bits, cleared), Q (dividend), D (divisor); count=0; go to RUN; busy=1 from the next cycle.
- IDLE, start=1, divisor==0: go to ZERO; busy=1 for that one cycle.
- RUN iteration, per edge:
  - shift {A,Q} left by 1;
  - trial T = A - {0,D}, computed at WIDTH+1 bits;
  - if T is non-negative: A=T and Q[0]=1; else keep A and set Q[0]=0;
  - count increments.
- RUN completion: on the edge where count reaches WIDTH-1 (the WIDTH-th iteration), the final Q and A[WIDTH-1:0] are written to quotient and remainder, done=1 for the following cycle, busy=0, and the state returns to IDLE.
- Latency: start accepted at edge k gives done high in the cycle after edge k+WIDTH (32 cycles for default WIDTH).
- ZERO: on the next edge, quotient = all ones, remainder = dividend, div_by_zero=1, done=1, busy=0, return to IDLE. Latency is 1 cycle.
- div_by_zero is cleared on any normal completion.
- start while busy=1 is ignored; no queuing.
- start in the same cycle as the done pulse is accepted, because busy is already 0. Back-to-back throughput is therefore WIDTH+1 cycles per operation.
- done is never asserted for more than one cycle.
- quotient and remainder change only on completion edges.

Optional Feature:
DIV_SIGNED_EN.
With the macro defined:
- The signed_op port exists.
- When signed_op=1 at accept, magnitudes of dividend and divisor are captured, and the unsigned core runs unchanged.
- At completion: quotient is negated if the operand signs differ; remainder takes the sign of the dividend (truncation toward zero).
- Overflow case dividend=0x80000000, divisor=0xFFFFFFFF: quotient=0x80000000, remainder=0, normal 32-cycle latency.
- Signed divide-by-zero: quotient=0xFFFFFFFF, remainder=dividend.
- Sign bookkeeping adds no latency.
Without the macro: no signed_op port, and all operations are unsigned.

Test Plan:
1. dividend=100, divisor=7, start pulse at edge k -> busy=1 for cycles k+1..k+32, done=1 exactly in the cycle after edge k+32, quotient=14, remainder=2, div_by_zero=0.
2. dividend=0x12345678, divisor=0 -> done one cycle after accept, quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1. A following 9/3 operation must give quotient=3, remainder=0, div_by_zero=0.
3. dividend=0xFFFFFFFF with divisor=1, then divisor=0xFFFFFFFF -> first q=0xFFFFFFFF/r=0, then q=1/r=0. Dividend 5 / divisor 9 -> q=0, r=5.
4. start=1 held continuously with new operands each cycle -> only the operands captured at the accepting edges are used, each result appears 33 cycles apart, and exactly one done pulse per operation.
5. rst=1 at iteration 10 of 100/7 -> all outputs return to 0 on the next edge, no done pulse, and a new start afterwards completes correctly.
6. (DIV_SIGNED_EN) signed_op=1:
   - -7/2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1);
   - 7/-2 -> q=-3, r=1;
   - 0x80000000/-1 -> q=0x80000000, r=0;
   - signed_op=0 with 0xFFFFFFF9/2 -> q=0x7FFFFFFC, r=1.
